// File: rtl/interval_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets and
// CONTROL/STATUS field positions.
package interval_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;
  localparam int unsigned PRESC_LSB  = 4;
  localparam int unsigned PRESC_MSB  = 11;
  localparam int unsigned CTRL_W     = 12;

  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/interval_timer_channel.sv
// One timer channel: prescaled down-counter with period, snapshot, control
// and status registers plus a local read mux.
module interval_timer_channel
  import interval_timer_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        tick_pulse_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [7:0]        presc_cnt_q, presc_cnt_d;
  logic              run_q, run_d;
  logic              to_q, to_d;
  logic              pulse_q, pulse_d;
  logic              force_reload_q;

  logic       wr_status, wr_control, wr_period, wr_snap;
  logic       tick;
  logic [7:0] presc;
  logic       unused_wdata;

  assign wr_status  = wr_i && (off_i == REG_STATUS);
  assign wr_control = wr_i && (off_i == REG_CONTROL);
  assign wr_period  = wr_i && (off_i == REG_PERIOD);
  assign wr_snap    = wr_i && (off_i == REG_SNAP);

  assign presc        = ctrl_q[PRESC_MSB:PRESC_LSB];
  assign tick         = run_q && (presc_cnt_q == 8'd0);
  assign unused_wdata = ^wdata_i;

  always_comb begin
    cnt_d       = cnt_q;
    period_d    = period_q;
    snap_d      = snap_q;
    ctrl_d      = ctrl_q;
    presc_cnt_d = presc_cnt_q;
    run_d       = run_q;
    to_d        = to_q;
    pulse_d     = 1'b0;

    if (run_q) begin
      presc_cnt_d = tick ? presc : presc_cnt_q - 8'd1;
    end

    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        to_d    = 1'b1;
        pulse_d = 1'b1;
        cnt_d   = period_q;
        if (!ctrl_q[CTRL_CONT]) begin
          run_d = 1'b0;
        end
      end
    end

    // A pending reload overrides any tick in the same cycle, including a timeout.
    if (force_reload_q) begin
      cnt_d       = period_q;
      presc_cnt_d = presc;
      run_d       = 1'b0;
      to_d        = to_q;
      pulse_d     = 1'b0;
    end

    if (wr_status) begin
      to_d = 1'b0;
    end

    if (wr_control) begin
      ctrl_d = wdata_i[CTRL_W-1:0];
      if (wdata_i[CTRL_START]) begin
        run_d       = 1'b1;
        presc_cnt_d = wdata_i[PRESC_MSB:PRESC_LSB];
      end else if (wdata_i[CTRL_STOP]) begin
        run_d = 1'b0;
      end
    end

    if (wr_period) begin
      period_d = wdata_i[CNT_W-1:0];
    end

    if (wr_snap) begin
      snap_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q          <= CNT_W'(DEFAULT_PERIOD);
      period_q       <= CNT_W'(DEFAULT_PERIOD);
      snap_q         <= '0;
      ctrl_q         <= '0;
      presc_cnt_q    <= '0;
      run_q          <= 1'b0;
      to_q           <= 1'b0;
      pulse_q        <= 1'b0;
      force_reload_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      snap_q         <= snap_d;
      ctrl_q         <= ctrl_d;
      presc_cnt_q    <= presc_cnt_d;
      run_q          <= run_d;
      to_q           <= to_d;
      pulse_q        <= pulse_d;
      force_reload_q <= wr_period;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (off_i)
      REG_STATUS: begin
        rdata_o[STAT_TO]  = to_q;
        rdata_o[STAT_RUN] = run_q;
      end
      REG_CONTROL: rdata_o = 32'(ctrl_q);
      REG_PERIOD:  rdata_o = 32'(period_q);
      REG_SNAP:    rdata_o = 32'(snap_q);
      default:     rdata_o = '0;
    endcase
  end

  assign irq_o        = to_q && ctrl_q[CTRL_ITO];
  assign tick_pulse_o = pulse_q;

endmodule

// File: rtl/interval_timer_mc.sv
// Multi-channel Avalon-MM interval timer: address decode, channel array,
// registered read data and combined interrupt.
module interval_timer_mc
  import interval_timer_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  parameter int unsigned ADDR_W         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_ch,
  output logic [NUM_CH-1:0] tick_pulse
);

  logic [29:0]       ch_sel;
  logic [NUM_CH-1:0] wr_en;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rd_mux;

  // Channel index is everything above the 2-bit register offset.
  assign ch_sel = 30'(32'(address) >> 2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = chipselect && !write_n && (ch_sel == 30'(i));

    interval_timer_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk_i       (clk),
      .reset_i     (reset),
      .wr_i        (wr_en[i]),
      .off_i       (address[1:0]),
      .wdata_i     (writedata),
      .rdata_o     (ch_rdata[i]),
      .irq_o       (irq_ch[i]),
      .tick_pulse_o(tick_pulse[i])
    );
  end

  // Out-of-range channel indices fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 30'(i)) begin
        rd_mux = ch_rdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= chipselect ? rd_mux : '0;
    end
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_interval_timer_mc.sv
// Directed self-checking bench for interval_timer_mc (3 channels, 16-bit counters).
module tb_interval_timer_mc;

  localparam int unsigned NUM_CH         = 3;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned DEFAULT_PERIOD = 49999;
  localparam int unsigned ADDR_W         = $clog2(NUM_CH) + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_ch;
  logic [NUM_CH-1:0] tick_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interval_timer_mc #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_PERIOD(DEFAULT_PERIOD),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_ch    (irq_ch),
    .tick_pulse(tick_pulse)
  );

  // Bus tasks are entered at a negedge and consume exactly one posedge.
  task automatic bus_write(input int unsigned ch, input int unsigned off, input logic [31:0] d);
    address    = ADDR_W'(ch * 4 + off);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int unsigned ch, input int unsigned off, output logic [31:0] d);
    address    = ADDR_W'(ch * 4 + off);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d          = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_val [4];
    exp_val = '{32'd0, 32'd0, 32'd49999, 32'd0};
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({irq, irq_ch, tick_pulse, readdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got irq=%b irq_ch=%b tick=%b rd=%0h want all 0",
               irq, irq_ch, tick_pulse, readdata);
    end
    reset = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      for (int off = 0; off < 4; off++) begin
        bus_read(ch, off, rd);
        total++;
        if (rd !== exp_val[off]) begin
          bad++;
          $display("FAIL reset_reg ch%0d off%0d: got %0d want %0d", ch, off, rd, exp_val[off]);
        end
      end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    bus_write(0, 2, 32'hABCD_0003);
    idle(1);
    bus_read(0, 2, rd);
    total++;
    if (rd !== 32'd3) begin bad++; $display("FAIL period_trunc: got %0h want 3", rd); end
    bus_write(0, 1, 32'h7);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (tick_pulse[0] !== (k % 4 == 0)) begin
        bad++;
        $display("FAIL periodic_pulse k=%0d: got %b want %b", k, tick_pulse[0], (k % 4 == 0));
      end
      total++;
      if (irq_ch[0] !== (k >= 4) || irq !== (k >= 4)) begin
        bad++;
        $display("FAIL periodic_irq k=%0d: got %b/%b want %b", k, irq_ch[0], irq, (k >= 4));
      end
    end
    idle(2);
    bus_write(0, 0, 32'h0);
    total++;
    if (irq_ch[0] !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL irq_cleared: got %b/%b want 0", irq_ch[0], irq);
    end
    @(negedge clk);
    total++;
    if (irq_ch[0] !== 1'b1 || tick_pulse[0] !== 1'b1) begin
      bad++; $display("FAIL irq_rearm: got irq=%b tick=%b want 1/1", irq_ch[0], tick_pulse[0]);
    end
    idle(3);
    bus_write(0, 0, 32'h0);
    total++;
    if (tick_pulse[0] !== 1'b1 || irq_ch[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_on_timeout: got tick=%b irq=%b want 1/0", tick_pulse[0], irq_ch[0]);
    end
    bus_read(0, 0, rd);
    total++;
    if (rd !== 32'd2) begin bad++; $display("FAIL status_after_clear: got %0h want 2", rd); end
    bus_write(0, 1, 32'h8);
    bus_write(0, 0, 32'h0);
    bus_read(0, 0, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL status_stopped: got %0h want 0", rd); end
    bus_read(0, 1, rd);
    total++;
    if (rd !== 32'h8) begin bad++; $display("FAIL control_readback: got %0h want 8", rd); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    bus_write(1, 2, 32'd2);
    idle(1);
    bus_write(1, 1, 32'h45);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++;
      if (tick_pulse[1] !== (k == 15)) begin
        bad++; $display("FAIL oneshot_pulse k=%0d: got %b want %b", k, tick_pulse[1], (k == 15));
      end
    end
    bus_read(1, 0, rd);
    total++;
    if (rd !== 32'd1) begin bad++; $display("FAIL oneshot_status: got %0h want 1", rd); end
    total++;
    if (irq_ch[1] !== 1'b1 || irq !== 1'b1) begin
      bad++; $display("FAIL oneshot_irq: got %b/%b want 1/1", irq_ch[1], irq);
    end
    bus_write(1, 0, 32'h0);
  endtask

  task automatic test_force_reload();
    logic [31:0] rd;
    bus_write(0, 2, 32'd100);
    idle(1);
    bus_write(0, 1, 32'h6);
    idle(5);
    bus_write(0, 2, 32'd10);
    idle(1);
    bus_read(0, 0, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL reload_run: got %0h want 0", rd); end
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd);
    total++;
    if (rd !== 32'd10) begin bad++; $display("FAIL reload_snap: got %0d want 10", rd); end
    bus_write(0, 1, 32'h6);
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) bus_write(0, 3, 32'h0);
      else @(negedge clk);
      total++;
      if (tick_pulse[0] !== (k == 11)) begin
        bad++; $display("FAIL reload_pulse k=%0d: got %b want %b", k, tick_pulse[0], (k == 11));
      end
    end
    bus_write(0, 1, 32'h8);
    bus_write(0, 0, 32'h0);
    bus_read(0, 3, rd);
    total++;
    if (rd !== 32'd8) begin bad++; $display("FAIL snap_pre_edge: got %0d want 8", rd); end
  endtask

  task automatic test_start_stop();
    logic [31:0] rd;
    bus_write(1, 1, 32'hC);
    bus_read(1, 0, rd);
    total++;
    if (rd !== 32'd2) begin bad++; $display("FAIL start_wins: got %0h want 2", rd); end
    bus_read(1, 1, rd);
    total++;
    if (rd !== 32'hC) begin bad++; $display("FAIL start_stop_readback: got %0h want c", rd); end
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'h0);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    bus_write(3, 2, 32'd5);
    bus_write(3, 1, 32'h7);
    bus_write(3, 3, 32'h0);
    for (int off = 0; off < 4; off++) begin
      bus_read(3, off, rd);
      total++;
      if (rd !== 32'd0) begin bad++; $display("FAIL oor_read off%0d: got %0h want 0", off, rd); end
    end
    bus_read(0, 2, rd);
    total++;
    if (rd !== 32'd10) begin bad++; $display("FAIL oor_ch0_period: got %0d want 10", rd); end
    bus_read(1, 2, rd);
    total++;
    if (rd !== 32'd2) begin bad++; $display("FAIL oor_ch1_period: got %0d want 2", rd); end
    bus_read(2, 2, rd);
    total++;
    if (rd !== 32'd49999) begin bad++; $display("FAIL oor_ch2_period: got %0d want 49999", rd); end
    bus_read(2, 0, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL oor_ch2_status: got %0h want 0", rd); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oor_irq: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] rd;
    bus_write(0, 1, 32'h7);
    bus_write(1, 2, 32'd3);
    idle(1);
    bus_write(1, 1, 32'h7);
    idle(15);
    total++;
    if (irq !== 1'b1 || irq_ch[1:0] !== 2'b11) begin
      bad++; $display("FAIL pre_reset_irq: got %b/%b want 1/11", irq, irq_ch[1:0]);
    end
    bus_read(0, 2, rd);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({irq, irq_ch, tick_pulse, readdata} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got irq=%b irq_ch=%b tick=%b rd=%0h want all 0",
               irq, irq_ch, tick_pulse, readdata);
    end
    reset = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      bus_write(ch, 3, 32'h0);
      bus_read(ch, 3, rd);
      total++;
      if (rd !== 32'd49999) begin
        bad++; $display("FAIL mid_reset_cnt ch%0d: got %0d want 49999", ch, rd);
      end
      bus_read(ch, 0, rd);
      total++;
      if (rd !== 32'd0) begin
        bad++; $display("FAIL mid_reset_status ch%0d: got %0h want 0", ch, rd);
      end
      bus_read(ch, 1, rd);
      total++;
      if (rd !== 32'd0) begin
        bad++; $display("FAIL mid_reset_control ch%0d: got %0h want 0", ch, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_force_reload();
    test_start_stop();
    test_out_of_range();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_timer_mc.md
# interval_timer_mc

Multi-channel Avalon-MM interval timer. The next generation of the system clock timer: `NUM_CH` independent down-counters of parametrised width, each with its own period, snapshot, control and status registers, and an 8-bit prescaler. Each channel drives a per-channel interrupt, and one OR-combined interrupt goes to the Nios II. Sits on the system interconnect as a 32-bit slave.

## Interface
- `NUM_CH`, 2 — channel count, 1..8.
- `CNT_W`, 32 — counter/period width, 8..32.
- `DEFAULT_PERIOD`, 49999 — reset value of every channel's period and counter; must fit in `CNT_W`.
- `ADDR_W`, derived = clog2(`NUM_CH`)+2 — word address width.

Ports:
- `clk` in 1 — single clock for all logic.
- `reset` in 1 — synchronous, active-high.
- `address` in `ADDR_W` — word address; upper bits = channel, low 2 bits = register.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write.
- `writedata` in 32 — write data.
- `readdata` out 32 — registered read data, 1-cycle latency.
- `irq` out 1 — OR of `irq_ch`.
- `irq_ch` out `NUM_CH` — per-channel interrupt, level.
- `tick_pulse` out `NUM_CH` — 1-cycle strobe on each channel timeout, independent of interrupt enable.

## Operation
- Register map per channel (offset in low 2 address bits):
  - 0 STATUS: bit0 TO (timeout latched), bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT (continuous), bit2 START, bit3 STOP, bits[11:4] PRESC. Bits [11:0] are stored; START and STOP act as strobes on write and read back as last written.
  - 2 PERIOD: bits[`CNT_W`-1:0]. Upper bits are ignored on write and read as 0.
  - 3 SNAP: a write of any value copies the counter into the snapshot; a read returns the snapshot.
- Write strobe = `chipselect` & ~`write_n` & channel match & offset match. Unused read bits are 0. Channel indices ≥ `NUM_CH` read 0 and ignore writes.
- Prescaler: `presc_cnt` counts down PRESC..0. A tick occurs when RUN and `presc_cnt`==0; `presc_cnt` then reloads PRESC. PRESC=0 gives a tick every clock.
- On a tick with counter≠0 the counter decrements.
- On a tick with counter==0:
  - timeout event: set TO, pulse `tick_pulse` for one cycle, reload the counter from PERIOD;
  - if CONT=0, clear RUN.
- Period between timeouts is therefore (PERIOD+1)×(PRESC+1) clocks.
- A PERIOD write sets `force_reload` for the next cycle. That cycle reloads the counter from the new PERIOD, reloads `presc_cnt`, and clears RUN. Software must START again.
- START sets RUN and reloads `presc_cnt`. It does not reload the counter; counting resumes from the current value.
- `irq_ch[i]` = TO & ITO.

## Timing
- Reset values: `readdata`=0, `irq`=0, `irq_ch`=0, `tick_pulse`=0. Per channel: counter=PERIOD=`DEFAULT_PERIOD`, snapshot=0, CONTROL=0, TO=0, RUN=0, `presc_cnt`=0.
- Read: `readdata` is valid on the clock after the address is presented. There are no wait states.
- Write takes effect at the clock edge where it is sampled. START/STOP change RUN at that edge. Counting begins on the following cycle (first tick after PRESC+1 clocks).
- Timeout: TO, `irq_ch` and `tick_pulse` are asserted the cycle after the zero-tick edge, i.e. they are registered.
- Simultaneous events:
  - START and STOP in the same write: START wins.
  - STATUS write in the same cycle as a timeout event: the clear wins, TO=0.
  - `force_reload` in the same cycle as a zero-tick: the reload from the new PERIOD wins, RUN=0, and no timeout is recorded.
  - SNAP write during a decrement: the snapshot captures the pre-edge counter value.
- Reset asserted mid-count returns every register to its reset value at the next edge; no pulse or irq is emitted.
- A PERIOD=0 write with CONT=1 gives a timeout on every tick.

## Structure
- Package `interval_timer_pkg`: register offset constants (`REG_STATUS`/`REG_CONTROL`/`REG_PERIOD`/`REG_SNAP`), CONTROL bit positions, PRESC field bounds, STATUS bit positions.
- Sub-module `interval_timer_channel`: one channel, containing counter, prescaler, RUN/TO, PERIOD/CONTROL/SNAP registers and a local read mux. Instantiated `NUM_CH` times via generate.
- Top level: address decode to per-channel write strobes, channel read-data select, `readdata` register, `irq` OR.

## Test plan
- Reset, then read all registers of ch0 and ch1 -> PERIOD=49999, CONTROL=0, STATUS=0, SNAP=0; `irq`=0.
- Ch0: PERIOD=3, CONTROL=ITO|CONT|START, PRESC=0 -> `tick_pulse[0]` every 4 clocks; `irq_ch[0]` high after the first timeout; a STATUS write drops it for 1 cycle before it rises again at the next timeout.
- Ch1: PERIOD=2, PRESC=4, CONT=0, START -> exactly one timeout 15 clocks after START; RUN reads 0 afterwards; no further pulses.
- Ch0 running with PERIOD=100 -> write PERIOD=10 -> RUN=0 the next cycle and the counter reads 10 via SNAP; START -> first timeout 11 clocks later.
- Corner cases:
  - START|STOP write -> RUN=1.
  - STATUS write on the timeout cycle -> TO=0.
  - Writes to channel index ≥ `NUM_CH` -> no effect; reads return 0.
- Assert `reset` mid-count on both channels -> all outputs 0 the next cycle and counters = 49999.
